// File: rtl/ppe_pkg.sv
`default_nettype none
// ============================================================================
// ppe_pkg : shared opcodes, FSM state type and packet field helpers
// Rev 1.0
// ============================================================================
package ppe_pkg;

    localparam logic OP_WEIGHT = 1'b0;
    localparam logic OP_INPUT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_SEND    = 2'd2,
        ST_REQ     = 2'd3
    } state_t;

    // Packets are zero-extended to 64 bits; callers cast the result to width.
    function automatic logic [63:0] pkt_data(input logic [63:0] pkt, input int data_w);
        return pkt & ((64'd1 << data_w) - 64'd1);
    endfunction

    function automatic logic pkt_opcode(input logic [63:0] pkt, input int data_w);
        return pkt[data_w];
    endfunction

    function automatic logic [63:0] pkt_addr(input logic [63:0] pkt, input int addr_w,
                                             input int data_w);
        return (pkt >> (data_w + 1)) & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppe_stream_if.sv
`default_nettype none
// ============================================================================
// ppe_stream_if : router-side and SPE-side packet handshakes of the PE
// Rev 1.0
// ============================================================================
interface ppe_stream_if #(
    parameter int PKT_W = 30
);
    logic [PKT_W-1:0] in_pkt;
    logic             in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] out_pkt;
    logic             out_valid;
    logic             out_ready;
    logic             err_no_weights;

    modport master (
        output in_pkt, in_valid, out_ready,
        input  in_ready, out_pkt, out_valid, err_no_weights
    );

    modport slave (
        input  in_pkt, in_valid, out_ready,
        output in_ready, out_pkt, out_valid, err_no_weights
    );
endinterface
`default_nettype wire

// File: rtl/ppe_wbank.sv
`default_nettype none
// ============================================================================
// ppe_wbank : kernel-row weight register file, multi-slot write, tap read
// Rev 1.0
// ============================================================================
module ppe_wbank #(
    parameter int FILTER_SIZE = 5,
    parameter int WEIGHT_W    = 8,
    parameter int WPP         = 3,
    parameter int TAP_W       = 3
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      wr_en,
    input  wire logic [WPP*WEIGHT_W-1:0]   wr_data,
    input  wire logic [TAP_W-1:0]          rd_tap,
    output      logic [WEIGHT_W-1:0]       rd_weight,
    output      logic                      loaded
);
    localparam int PTR_W = $clog2(FILTER_SIZE + 1);

    logic [WEIGHT_W-1:0] weight     [FILTER_SIZE];
    logic [WEIGHT_W-1:0] weight_nxt [FILTER_SIZE];
    logic [PTR_W-1:0]    wptr;

    // Slots landing past the end of the row are simply never matched.
    always_comb begin
        weight_nxt = weight;
        for (int j = 0; j < FILTER_SIZE; j++) begin
            for (int k = 0; k < WPP; k++) begin
                if (int'(wptr) + k == j) begin
                    weight_nxt[j] = wr_data[k*WEIGHT_W +: WEIGHT_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FILTER_SIZE; j++) begin
                weight[j] <= '0;
            end
            wptr   <= '0;
            loaded <= 1'b0;
        end else if (wr_en) begin
            weight <= weight_nxt;
            if (int'(wptr) + WPP >= FILTER_SIZE) begin
                wptr   <= '0;
                loaded <= 1'b1;
            end else begin
                wptr <= wptr + PTR_W'(WPP);
            end
        end
    end

    assign rd_weight = weight[rd_tap];

endmodule
`default_nettype wire

// File: rtl/ppe_stream.sv
`default_nettype none
// ============================================================================
// ppe_stream : sliding-window partial-sum PE, round-robin SPE steering
// Rev 1.0
// ============================================================================
module ppe_stream
    import ppe_pkg::*;
#(
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int WEIGHT_W     = 8,
    parameter int SUM_W        = 13,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 25,
    parameter int NUM_SPE      = 5,
    parameter int SPE_BASE     = 0,
    parameter int IFMAP_MEM_ID = 10
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    ppe_stream_if.slave  bus
);
    localparam int PKT_W   = ADDR_W + 1 + DATA_W;
    localparam int WPP     = DATA_W / WEIGHT_W;
    localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int TAP_W   = $clog2(FILTER_SIZE > 1 ? FILTER_SIZE : 2);
    localparam int COL_W   = $clog2(OUT_DIM > 1 ? OUT_DIM : 2);
    localparam int IDX_W   = $clog2(IFMAP_SIZE > 1 ? IFMAP_SIZE : 2);
    localparam int SPE_W   = $clog2(NUM_SPE > 1 ? NUM_SPE : 2);

    state_t                 state;
    logic [IFMAP_SIZE-1:0]  row;
    logic [COL_W-1:0]       col;
    logic [TAP_W-1:0]       tap;
    logic [SUM_W-1:0]       acc;
    logic [SPE_W-1:0]       spe_ptr;
    logic [PKT_W-1:0]       out_pkt;
    logic                   out_valid;
    logic                   err_flag;

    logic [DATA_W-1:0]      in_data;
    logic                   in_op;
    logic                   wr_en;
    logic                   loaded;
    logic [WEIGHT_W-1:0]    tap_weight;
    logic [IDX_W-1:0]       win_idx;
    logic [SUM_W-1:0]       acc_next;
    logic [ADDR_W-1:0]      spe_addr;

    assign in_data = DATA_W'(pkt_data(64'(bus.in_pkt), DATA_W));
    assign in_op   = pkt_opcode(64'(bus.in_pkt), DATA_W);
    assign wr_en   = (state == ST_IDLE) && bus.in_valid && (in_op == OP_WEIGHT);

    ppe_wbank #(
        .FILTER_SIZE (FILTER_SIZE),
        .WEIGHT_W    (WEIGHT_W),
        .WPP         (WPP),
        .TAP_W       (TAP_W)
    ) u_wbank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (in_data[WPP*WEIGHT_W-1:0]),
        .rd_tap    (tap),
        .rd_weight (tap_weight),
        .loaded    (loaded)
    );

    assign win_idx  = IDX_W'(col) + IDX_W'(tap);
    assign acc_next = acc + (row[win_idx]
                      ? {{(SUM_W-WEIGHT_W){tap_weight[WEIGHT_W-1]}}, tap_weight}
                      : {SUM_W{1'b0}});
    assign spe_addr = ADDR_W'(SPE_BASE) + ADDR_W'(spe_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            tap       <= '0;
            acc       <= '0;
            spe_ptr   <= '0;
            out_pkt   <= '0;
            out_valid <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_op == OP_INPUT) begin
                        if (!loaded) begin
                            err_flag <= 1'b1;
                        end else begin
                            row   <= in_data[IFMAP_SIZE-1:0];
                            col   <= '0;
                            tap   <= '0;
                            acc   <= '0;
                            state <= ST_COMPUTE;
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc <= acc_next;
                    // Last tap folds straight into the outgoing packet.
                    if (tap == TAP_W'(FILTER_SIZE - 1)) begin
                        out_pkt   <= {spe_addr, OP_WEIGHT,
                                      {(DATA_W-SUM_W){acc_next[SUM_W-1]}}, acc_next};
                        out_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        spe_ptr <= (spe_ptr == SPE_W'(NUM_SPE - 1)) ? '0 : spe_ptr + 1'b1;
                        if (col == COL_W'(OUT_DIM - 1)) begin
                            out_pkt <= {ADDR_W'(IFMAP_MEM_ID), 1'b0, {DATA_W{1'b0}}};
                            state   <= ST_REQ;
                        end else begin
                            col       <= col + 1'b1;
                            tap       <= '0;
                            acc       <= '0;
                            out_valid <= 1'b0;
                            state     <= ST_COMPUTE;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (state == ST_IDLE);
    assign bus.out_pkt        = out_pkt;
    assign bus.out_valid      = out_valid;
    assign bus.err_no_weights = err_flag;

endmodule
`default_nettype wire

// File: tb/tb_ppe_stream.sv
`default_nettype none
// ============================================================================
// tb_ppe_stream : directed self-checking bench for ppe_stream
// Rev 1.0
// ============================================================================
module tb_ppe_stream;

    localparam logic        OPW     = 1'b0;
    localparam logic        OPI     = 1'b1;
    localparam logic [29:0] REQ_PKT = {4'd10, 1'b0, 25'd0};

    logic clk;
    logic rst_n;

    ppe_stream_if #(.PKT_W(30)) bus ();

    ppe_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_spe  = 0;

    logic [29:0] got[$];
    int          first_lat;
    int          total_edges;
    int          stable_bad;
    bit          timed_out;

    function automatic logic [29:0] mk(input int a, input logic op, input logic [24:0] d);
        return {a[3:0], op, d};
    endfunction

    // Reference window sum for weights 1..5.
    function automatic logic [24:0] win_sum_15(input logic [24:0] r, input int c);
        int s = 0;
        for (int t = 0; t < 5; t++) begin
            if (r[c+t]) s += t + 1;
        end
        return 25'(s);
    endfunction

    task automatic send_pkt(input logic [29:0] p);
        bus.in_pkt   = p;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_pkt   = '0;
    endtask

    // Called at the negedge after the accept edge; edge counts include that edge.
    task automatic collect_row(input bit stall);
        logic [29:0] held = '0;
        bit          was_stalled = 0;
        int          edge_n = 1;
        got.delete();
        first_lat   = -1;
        total_edges = -1;
        stable_bad  = 0;
        timed_out   = 1;
        while (edge_n < 3000) begin
            if (was_stalled && (!bus.out_valid || bus.out_pkt !== held)) stable_bad++;
            bus.out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            was_stalled = 0;
            if (bus.out_valid) begin
                if (first_lat < 0) first_lat = edge_n;
                if (bus.out_ready) got.push_back(bus.out_pkt);
                else begin
                    was_stalled = 1;
                    held = bus.out_pkt;
                end
            end
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            if (got.size() == 22) begin
                total_edges = edge_n;
                timed_out   = 0;
                break;
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_spe = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_pkt !== 30'd0)
            begin failures++; $display("FAIL reset_out_pkt got=%h exp=0", bus.out_pkt); end
        checks++; if (bus.err_no_weights !== 1'b0)
            begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_no_weights); end
    endtask

    task automatic test_no_weights();
        bit saw_valid = 0;
        bit saw_busy  = 0;
        send_pkt(mk(0, OPI, 25'h1FFFFFF));
        repeat (12) begin
            if (bus.out_valid) saw_valid = 1;
            if (!bus.in_ready) saw_busy = 1;
            @(negedge clk);
        end
        checks++; if (bus.err_no_weights !== 1'b1)
            begin failures++; $display("FAIL nowt_err got=%b exp=1", bus.err_no_weights); end
        checks++; if (saw_valid !== 1'b0)
            begin failures++; $display("FAIL nowt_out_valid got=%b exp=0", saw_valid); end
        checks++; if (saw_busy !== 1'b0)
            begin failures++; $display("FAIL nowt_in_ready_dropped got=%b exp=0", saw_busy); end
    endtask

    task automatic test_ones_row();
        send_pkt(mk(0, OPW, {1'b0, 8'h03, 8'h02, 8'h01}));
        send_pkt(mk(0, OPW, {1'b0, 8'h7F, 8'h05, 8'h04}));
        send_pkt(mk(0, OPI, 25'h1FFFFFF));
        collect_row(1'b0);
        checks++; if (timed_out !== 1'b0)
            begin failures++; $display("FAIL ones_timeout got=%0d exp=22 pkts", got.size()); end
        checks++; if (first_lat != 6)
            begin failures++; $display("FAIL ones_first_latency got=%0d exp=6", first_lat); end
        checks++; if (total_edges != 128)
            begin failures++; $display("FAIL ones_row_edges got=%0d exp=128", total_edges); end
        checks++; if (bus.in_ready !== 1'b1)
            begin failures++; $display("FAIL ones_back_idle got=%b exp=1", bus.in_ready); end
        for (int i = 0; i < 21; i++) begin
            logic [29:0] e;
            e = mk(exp_spe, 1'b0, 25'd15);
            exp_spe = (exp_spe + 1) % 5;
            checks++; if (i >= got.size() || got[i] !== e)
                begin failures++; $display("FAIL ones_pkt%0d got=%h exp=%h", i, got[i], e); end
        end
        checks++; if (got.size() < 22 || got[21] !== REQ_PKT)
            begin failures++; $display("FAIL ones_req got=%h exp=%h", got[21], REQ_PKT); end
    endtask

    task automatic test_negative();
        send_pkt(mk(0, OPW, {1'b0, 8'h80, 8'h80, 8'h80}));
        send_pkt(mk(0, OPW, {1'b0, 8'h80, 8'h80, 8'h80}));
        send_pkt(mk(0, OPI, 25'h1FFFFFF));
        collect_row(1'b0);
        checks++; if (timed_out !== 1'b0)
            begin failures++; $display("FAIL neg_timeout got=%0d exp=22 pkts", got.size()); end
        for (int i = 0; i < 21; i++) begin
            logic [29:0] e;
            e = mk(exp_spe, 1'b0, 25'h1FFFD80);
            exp_spe = (exp_spe + 1) % 5;
            checks++; if (i >= got.size() || got[i] !== e)
                begin failures++; $display("FAIL neg_pkt%0d got=%h exp=%h", i, got[i], e); end
        end
    endtask

    task automatic test_single_spike();
        send_pkt(mk(0, OPW, {1'b0, 8'h03, 8'h02, 8'h01}));
        send_pkt(mk(0, OPW, {1'b0, 8'h00, 8'h05, 8'h04}));
        send_pkt(mk(0, OPI, 25'h0000010));
        collect_row(1'b0);
        checks++; if (timed_out !== 1'b0)
            begin failures++; $display("FAIL spike_timeout got=%0d exp=22 pkts", got.size()); end
        for (int i = 0; i < 21; i++) begin
            logic [29:0] e;
            e = mk(exp_spe, 1'b0, (i < 5) ? 25'(5 - i) : 25'd0);
            exp_spe = (exp_spe + 1) % 5;
            checks++; if (i >= got.size() || got[i] !== e)
                begin failures++; $display("FAIL spike_col%0d got=%h exp=%h", i, got[i], e); end
        end
        checks++; if (got.size() < 22 || got[21] !== REQ_PKT)
            begin failures++; $display("FAIL spike_req got=%h exp=%h", got[21], REQ_PKT); end
    endtask

    task automatic test_stall_two_rows();
        logic [24:0] rows [2];
        rows[0] = 25'h1234567;
        rows[1] = 25'h0F0F0F0;
        for (int r = 0; r < 2; r++) begin
            send_pkt(mk(0, OPI, rows[r]));
            collect_row(1'b1);
            checks++; if (timed_out !== 1'b0)
                begin failures++; $display("FAIL stall%0d_timeout got=%0d exp=22 pkts", r, got.size()); end
            checks++; if (stable_bad != 0)
                begin failures++; $display("FAIL stall%0d_hold got=%0d exp=0 changes", r, stable_bad); end
            for (int i = 0; i < 21; i++) begin
                logic [29:0] e;
                e = mk(exp_spe, 1'b0, win_sum_15(rows[r], i));
                exp_spe = (exp_spe + 1) % 5;
                checks++; if (i >= got.size() || got[i] !== e)
                    begin failures++; $display("FAIL stall%0d_pkt%0d got=%h exp=%h", r, i, got[i], e); end
            end
            checks++; if (got.size() < 22 || got[21] !== REQ_PKT)
                begin failures++; $display("FAIL stall%0d_req got=%h exp=%h", r, got[21], REQ_PKT); end
        end
    endtask

    task automatic test_async_reset();
        int  n = 0;
        int  sent = 0;
        bit  saw_valid = 0;
        send_pkt(mk(0, OPI, 25'h1FFFFFF));
        bus.out_ready = 1'b1;
        while (sent < 2 && n < 200) begin
            if (bus.out_valid) sent++;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        while (!bus.out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.out_valid !== 1'b1)
            begin failures++; $display("FAIL areset_third_send got=%b exp=1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL areset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_pkt !== 30'd0)
            begin failures++; $display("FAIL areset_out_pkt got=%h exp=0", bus.out_pkt); end
        checks++; if (bus.in_ready !== 1'b1)
            begin failures++; $display("FAIL areset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.err_no_weights !== 1'b0)
            begin failures++; $display("FAIL areset_err got=%b exp=0", bus.err_no_weights); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        exp_spe = 0;
        @(negedge clk);
        send_pkt(mk(0, OPI, 25'h1FFFFFF));
        repeat (10) begin
            if (bus.out_valid) saw_valid = 1;
            @(negedge clk);
        end
        checks++; if (bus.err_no_weights !== 1'b1)
            begin failures++; $display("FAIL areset_weights_lost got=%b exp=1", bus.err_no_weights); end
        checks++; if (saw_valid !== 1'b0)
            begin failures++; $display("FAIL areset_no_output got=%b exp=0", saw_valid); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_pkt    = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_no_weights();
        test_ones_row();
        test_negative();
        test_single_spike();
        test_stall_two_rows();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ppe_stream.md
# ppe_stream

Clocked, parametrised successor to the CSP partial-sum PE. It stores one kernel row of signed weights and accepts binary ifmap rows, one row per packet. For each row it slides a FILTER_SIZE window across the row and emits one partial-sum packet per output column, steering the packets round-robin across NUM_SPE summing PEs. After the last window of a row it sends a row request to the ifmap memory. It sits between the NoC router port and the SPE array.

## Interface
- FILTER_SIZE, 5: kernel row length, which is also the weight storage depth.
- IFMAP_SIZE, 25: input row length in 1-bit spikes. Must satisfy IFMAP_SIZE ≤ DATA_W.
- WEIGHT_W, 8: signed weight width.
- SUM_W, 13: signed accumulator width. Must satisfy SUM_W ≥ WEIGHT_W + $clog2(FILTER_SIZE) + 1.
- ADDR_W, 4: destination-address field width.
- DATA_W, 25: data field width. Packet width PKT_W = ADDR_W + 1 + DATA_W.
- NUM_SPE, 5: number of SPE destinations.
- SPE_BASE, 0: address of SPE 0.
- IFMAP_MEM_ID, 10: ifmap memory address.
- clk, input, 1: clock, all state on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_pkt, input, PKT_W: packet fields {addr[PKT_W-1 -: ADDR_W], opcode[DATA_W], data[DATA_W-1:0]}. Opcode 0 = WEIGHT, 1 = INPUT.
- in_valid, input, 1: in_pkt is valid.
- in_ready, output, 1: block accepts in_pkt this cycle.
- out_pkt, output, PKT_W: outgoing packet, same format as in_pkt.
- out_valid, output, 1: out_pkt is valid.
- out_ready, input, 1: downstream accepts out_pkt.
- err_no_weights, output, 1: sticky. Set when an INPUT packet arrives before weights are loaded.

## Operation
- Handshakes:
  - A transfer happens on a rising edge where valid and ready are both high.
  - out_pkt and out_valid are held stable until the transfer completes.
  - out_valid never depends combinationally on out_ready.
- States:
  - IDLE: in_ready = 1.
  - COMPUTE: accumulates one window.
  - SEND: offers the partial-sum packet.
  - REQ: offers the row-request packet.
- WEIGHT packet accepted in IDLE:
  - WPP = DATA_W / WEIGHT_W. With the defaults, WPP = 3.
  - Slot k (data[k*WEIGHT_W +: WEIGHT_W], k = 0..WPP-1) is written to weight[wptr+k] while wptr+k < FILTER_SIZE. Slots beyond that are dropped.
  - wptr advances by the number of weights written.
  - When wptr reaches FILTER_SIZE, set weights_loaded and wrap wptr to 0. A later load overwrites from index 0.
  - Next state stays IDLE.
- INPUT packet accepted in IDLE with weights_loaded = 0: set err_no_weights, discard the packet, stay in IDLE.
- INPUT packet accepted in IDLE with weights_loaded = 1:
  - Latch data[IFMAP_SIZE-1:0] as the row. Set col = 0, tap = 0, acc = 0. Go to COMPUTE.
- COMPUTE, one tap per cycle:
  - If row[col+tap] = 1, acc += sign-extended weight[tap].
  - After tap = FILTER_SIZE-1, build the partial-sum packet and go to SEND.
  - Packet: addr = SPE_BASE + spe_ptr, opcode = 0, data = acc sign-extended to DATA_W.
- SEND, on transfer:
  - spe_ptr advances, wrapping to 0 after NUM_SPE-1. spe_ptr persists across rows.
  - If col = OUT_DIM-1, where OUT_DIM = IFMAP_SIZE-FILTER_SIZE+1, go to REQ.
  - Otherwise col += 1, tap = 0, acc = 0, go to COMPUTE.
- REQ:
  - out_pkt = {IFMAP_MEM_ID, 0, 0}.
  - On transfer go to IDLE.
- Arithmetic: two's complement. With these parameter constraints overflow cannot occur, so there is no saturation.

## Timing
- Reset values:
  - State IDLE, in_ready = 1.
  - out_valid = 0, out_pkt = 0, err_no_weights = 0.
  - wptr = 0, weights_loaded = 0, spe_ptr = 0, acc = 0.
- Reset asserted mid-row aborts immediately. The current row, any pending packet and the loaded weights are all lost.
- Latency:
  - First out_valid of a row rises at the (FILTER_SIZE+1)th rising edge after the INPUT accept edge.
  - Each subsequent window follows FILTER_SIZE+1 edges after the previous SEND transfer.
  - The request packet is offered on the edge after the last SEND transfer.
- With out_ready tied high, a row takes OUT_DIM·(FILTER_SIZE+1) + 2 cycles from accept to IDLE. With the defaults that is 128.
- in_ready = 0 in COMPUTE, SEND and REQ. The block never buffers a second packet.
- A stalled out_ready holds the state indefinitely, with no loss or duplication.

## Structure
- Package ppe_pkg holds:
  - opcode constants OP_WEIGHT and OP_INPUT;
  - a state enum;
  - pkt_addr, pkt_opcode and pkt_data field-extract functions parametrised by ADDR_W and DATA_W.
- Sub-module ppe_wbank holds the FILTER_SIZE×WEIGHT_W register file. It has a multi-slot write port and one read port indexed by tap, and it owns wptr and weights_loaded.

## Test plan
- Reset, then INPUT data = 25'h1FFFFFF → err_no_weights = 1, no out_valid, in_ready stays 1.
- Weights {1, 2, 3} then {4, 5} (packet 2 slot 2 = 0x7F), then INPUT all-ones with out_ready high:
  - 21 packets, each data = 15, addresses SPE_BASE+0..4 repeating;
  - then {10, 0, 0};
  - first out_valid 6 edges after accept.
- Weights all -128, INPUT all-ones → every sum = -640, sign-extended (data = 25'h1FFFD80).
- INPUT row = 1 << 4, weights 1..5 → col 0 = 5, col 1 = 4, col 2 = 3, col 3 = 2, col 4 = 1, cols 5..20 = 0.
- Random out_ready stalls across two rows → identical data sequence, out_pkt stable while stalled, spe_ptr continues 1, 2, … into row 2.
- rst_n low during the 3rd SEND → all outputs return to reset values asynchronously. A following INPUT sets err_no_weights.
